// File: rtl/uart_rx_mmio_if.sv
// MMIO request/response bundle between the CPU-side bus and the UART receiver.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef UART_DIV
`define UART_DIV 16
`endif

interface uart_rx_mmio_if;
  logic              mmio_req;
  logic              mmio_we;
  logic [`ADDR_W-1:0] mmio_addr;
  logic [`XLEN-1:0]   mmio_wdata;
  logic              mmio_ready;
  logic [`XLEN-1:0]   mmio_rdata;

  modport master (
    output mmio_req, mmio_we, mmio_addr, mmio_wdata,
    input  mmio_ready, mmio_rdata
  );

  modport slave (
    input  mmio_req, mmio_we, mmio_addr, mmio_wdata,
    output mmio_ready, mmio_rdata
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a small receive FIFO, sticky error flags and an MMIO
// data/status register pair.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef UART_DIV
`define UART_DIV 16
`endif

// state     | meaning
// S_IDLE    | line idle, waiting for a falling edge
// S_START   | half-bit wait, confirm start bit
// S_DATA    | sampling 8 data bits, LSB first
// S_STOP    | sampling stop bit
// S_WAIT_HIGH | framing error seen, wait for line to return high
module uart_rx_mmio #(
  parameter int                 UART_DIV     = `UART_DIV,
  parameter int                 FIFO_DEPTH   = 8,
  parameter logic [`ADDR_W-1:0] RX_DATA_ADDR = `IO_BASE_ADDR + 32'h20,
  parameter logic [`ADDR_W-1:0] RX_STAT_ADDR = `IO_BASE_ADDR + 32'h24
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_mmio_if.slave  mmio,
  input  logic           uart_rx,
  output logic           rx_irq
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_FULL = 16'(UART_DIV - 1);
  localparam logic [15:0] CNT_HALF = 16'(UART_DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  logic rx_meta, rx_s;
  state_t state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overrun, frame_err;

  logic             ready_q, we_q, stat_hit_q;
  logic [2:0]       ctl_q;
  logic [`XLEN-1:0] rdata_q, rd_mux;

  logic stop_smp, push, frame_set, not_empty, full;
  logic accept, data_hit, stat_hit, pop, push_ok, ovr_set, wr_stat, flush;
  logic unused_wdata;

  assign unused_wdata = ^{mmio.mmio_wdata[`XLEN-1:4], mmio.mmio_wdata[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (!rx_s) begin
          state <= S_START;
          cnt   <= CNT_HALF;
        end
        S_START: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else if (!rx_s) begin
            state   <= S_DATA;
            cnt     <= CNT_FULL;
            bit_idx <= '0;
          end else state <= S_IDLE;
        end
        S_DATA: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else begin
            shift_q[bit_idx] <= rx_s;
            cnt              <= CNT_FULL;
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (cnt != 16'd0) cnt <= cnt - 16'd1;
          else state <= rx_s ? S_IDLE : S_WAIT_HIGH;
        end
        S_WAIT_HIGH: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_smp  = (state == S_STOP) && (cnt == 16'd0);
  assign push      = stop_smp && rx_s;
  assign frame_set = stop_smp && !rx_s;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign accept    = mmio.mmio_req && !ready_q;
  assign data_hit  = (mmio.mmio_addr == RX_DATA_ADDR);
  assign stat_hit  = (mmio.mmio_addr == RX_STAT_ADDR);
  assign pop       = accept && !mmio.mmio_we && data_hit && not_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok   = push && (!full || pop);
  assign ovr_set   = push && full && !pop;
  assign wr_stat   = ready_q && we_q && stat_hit_q;
  assign flush     = wr_stat && ctl_q[2];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (ovr_set) overrun <= 1'b1;
      else if (wr_stat && ctl_q[0]) overrun <= 1'b0;
      if (frame_set) frame_err <= 1'b1;
      else if (wr_stat && ctl_q[1]) frame_err <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (!mmio.mmio_we) begin
      if (data_hit && not_empty)
        rd_mux = `XLEN'({1'b1, mem[rd_ptr]});
      else if (stat_hit)
        rd_mux = `XLEN'({8'(count), 4'b0, 1'b0, frame_err, overrun, not_empty});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      stat_hit_q <= 1'b0;
      ctl_q      <= '0;
      rdata_q    <= '0;
      rx_irq     <= 1'b0;
    end else begin
      ready_q <= accept;
      rx_irq  <= not_empty | overrun | frame_err;
      if (accept) begin
        we_q       <= mmio.mmio_we;
        stat_hit_q <= stat_hit;
        ctl_q      <= mmio.mmio_wdata[3:1];
        rdata_q    <= rd_mux;
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign mmio.mmio_ready = ready_q;
  assign mmio.mmio_rdata = rdata_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio: serial frames are driven on uart_rx and the
// bytes read back over MMIO are checked against a small FIFO/flag model.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h1000_0000
`endif
`ifndef UART_DIV
`define UART_DIV 16
`endif

module tb_uart_rx_mmio;
  localparam int          DIV   = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] A_DATA = 32'h1000_0020;
  localparam logic [31:0] A_STAT = 32'h1000_0024;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_rx;
  logic rx_irq;

  uart_rx_mmio_if mif ();

  uart_rx_mmio #(
    .UART_DIV(DIV), .FIFO_DEPTH(DEPTH),
    .RX_DATA_ADDR(A_DATA), .RX_STAT_ADDR(A_STAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mmio(mif.slave), .uart_rx(uart_rx), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int   model_count = 0;
  logic model_ovr = 1'b0;
  logic model_fe  = 1'b0;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
    uart_rx = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cycles(DIV);
    end
    uart_rx = stop_bit;
    cycles(stop_len);
    uart_rx = 1'b1;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (model_count < DEPTH) begin
      sb.push_back(b);
      model_count++;
    end else model_ovr = 1'b1;
  endtask

  task automatic exp_data(output logic [31:0] e);
    if (sb.size() > 0) begin
      e = {23'b0, 1'b1, sb.pop_front()};
      model_count--;
    end else e = 32'h0;
  endtask

  function automatic logic [31:0] exp_stat();
    return {16'b0, 8'(model_count), 4'b0, 1'b0, model_fe, model_ovr, model_count != 0};
  endfunction

  task automatic mmio_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    int n;
    mif.mmio_req   = 1'b1;
    mif.mmio_we    = we;
    mif.mmio_addr  = addr;
    mif.mmio_wdata = wdata;
    @(posedge clk);
    #1;
    mif.mmio_req = 1'b0;
    n = 0;
    while (!mif.mmio_ready && n < 8) begin
      cycles(1);
      n++;
    end
    checks++;
    if (mif.mmio_ready !== 1'b1) begin
      errors++;
      $display("FAIL mmio_ready_timeout: ready=%b addr=%h, required ready=1", mif.mmio_ready, addr);
    end
    rdata = mif.mmio_rdata;
    cycles(1);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    uart_rx = 1'b1;
    mif.mmio_req = 1'b0;
    mif.mmio_we = 1'b0;
    mif.mmio_addr = '0;
    mif.mmio_wdata = '0;
    cycles(3);
    checks++;
    if ({mif.mmio_ready, mif.mmio_rdata, rx_irq} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, required all 0",
               mif.mmio_ready, mif.mmio_rdata, rx_irq);
    end
    rst_n = 1'b1;
    cycles(5);
    mmio_xfer(1'b0, A_STAT, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_stat: got %h required %h", got, 32'h0); end
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required %h", got, 32'h0); end
  endtask

  task automatic test_nominal();
    logic [31:0] got, e;
    send_byte(8'h5A, 1'b1, DIV);
    model_rx(8'h5A);
    cycles(4);
    checks++;
    if (rx_irq !== 1'b1) begin errors++; $display("FAIL nominal_irq_set: got %b required 1", rx_irq); end
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e || got !== 32'h101) begin errors++; $display("FAIL nominal_stat: got %h required %h", got, e); end
    mmio_xfer(1'b1, A_DATA, 32'hFF, got);
    mmio_xfer(1'b0, 32'h1000_0030, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required 0", got); end
    exp_data(e);
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== e || got !== 32'h15A) begin errors++; $display("FAIL nominal_data: got %h required %h", got, e); end
    exp_data(e);
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== e) begin errors++; $display("FAIL nominal_empty: got %h required %h", got, e); end
    cycles(2);
    checks++;
    if (rx_irq !== 1'b0) begin errors++; $display("FAIL nominal_irq_clear: got %b required 0", rx_irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] got, e;
    uart_rx = 1'b0;
    cycles(5);
    uart_rx = 1'b1;
    cycles(30);
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e) begin errors++; $display("FAIL glitch_stat: got %h required %h", got, e); end
    send_byte(8'hA5, 1'b1, DIV);
    model_rx(8'hA5);
    cycles(2);
    exp_data(e);
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== e) begin errors++; $display("FAIL glitch_next_byte: got %h required %h", got, e); end
  endtask

  task automatic test_frame_err();
    logic [31:0] got, e;
    send_byte(8'h33, 1'b0, 40);
    model_fe = 1'b1;
    cycles(20);
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e || got[2] !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %h required %h", got, e); end
    checks++;
    if (rx_irq !== 1'b1) begin errors++; $display("FAIL frame_err_irq: got %b required 1", rx_irq); end
    mmio_xfer(1'b1, A_STAT, 32'h4, got);
    model_fe = 1'b0;
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e) begin errors++; $display("FAIL frame_err_clear: got %h required %h", got, e); end
    send_byte(8'h33, 1'b1, DIV);
    model_rx(8'h33);
    cycles(2);
    exp_data(e);
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== e) begin errors++; $display("FAIL frame_err_next_byte: got %h required %h", got, e); end
  endtask

  task automatic test_overrun();
    logic [31:0] got, e;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b1, DIV);
      model_rx(8'(i));
    end
    cycles(2);
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e || got !== 32'h803) begin errors++; $display("FAIL overrun_stat: got %h required %h", got, e); end
    for (int i = 0; i < 9; i++) begin
      exp_data(e);
      mmio_xfer(1'b0, A_DATA, 0, got);
      checks++;
      if (got !== e) begin errors++; $display("FAIL overrun_data_%0d: got %h required %h", i, got, e); end
    end
    mmio_xfer(1'b1, A_STAT, 32'h2, got);
    model_ovr = 1'b0;
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e) begin errors++; $display("FAIL overrun_clear: got %h required %h", got, e); end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] got, e, got_b, e_b;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1, DIV);
      model_rx(8'(i));
    end
    // Read accepted on the same edge as the 9th byte's stop-bit sample
    // (2 sync flops + half bit + 8 data bits + full stop count).
    fork
      send_byte(8'h09, 1'b1, DIV);
      begin
        cycles(154);
        exp_data(e_b);
        mmio_xfer(1'b0, A_DATA, 0, got_b);
      end
    join
    model_rx(8'h09);
    checks++;
    if (got_b !== e_b) begin errors++; $display("FAIL popfull_read: got %h required %h", got_b, e_b); end
    cycles(2);
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e || got !== 32'h801) begin errors++; $display("FAIL popfull_stat: got %h required %h", got, e); end
    for (int i = 0; i < 8; i++) begin
      exp_data(e);
      mmio_xfer(1'b0, A_DATA, 0, got);
      checks++;
      if (got !== e) begin errors++; $display("FAIL popfull_data_%0d: got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] got, e;
    send_byte(8'hC3, 1'b1, DIV);
    model_rx(8'hC3);
    send_byte(8'h3C, 1'b1, DIV);
    model_rx(8'h3C);
    cycles(2);
    mmio_xfer(1'b1, A_STAT, 32'h8, got);
    sb.delete();
    model_count = 0;
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e) begin errors++; $display("FAIL flush_stat: got %h required %h", got, e); end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, e;
    send_byte(8'h11, 1'b1, DIV);
    model_rx(8'h11);
    cycles(2);
    fork
      send_byte(8'h7E, 1'b1, DIV);
      begin
        cycles(95);
        checks++;
        if (rx_irq !== 1'b1) begin errors++; $display("FAIL areset_irq_before: got %b required 1", rx_irq); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mif.mmio_ready, mif.mmio_rdata, rx_irq} !== 34'h0) begin
          errors++;
          $display("FAIL areset_outputs: ready=%b rdata=%h irq=%b, required all 0",
                   mif.mmio_ready, mif.mmio_rdata, rx_irq);
        end
      end
    join
    sb.delete();
    model_count = 0;
    cycles(5);
    rst_n = 1'b1;
    cycles(5);
    mmio_xfer(1'b0, A_STAT, 0, got);
    e = exp_stat();
    checks++;
    if (got !== e) begin errors++; $display("FAIL areset_stat: got %h required %h", got, e); end
    send_byte(8'h7E, 1'b1, DIV);
    model_rx(8'h7E);
    cycles(2);
    exp_data(e);
    mmio_xfer(1'b0, A_DATA, 0, got);
    checks++;
    if (got !== e || got !== 32'h17E) begin errors++; $display("FAIL areset_next_byte: got %h required %h", got, e); end
  endtask

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    mif.mmio_req = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_pop_push_full();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end
endmodule
